// File: rtl/datapath.sv
// Single-cycle MIPS32 subset core with built-in ROM, register file and data RAM.
// PC is an instruction index, not a byte address; RAM is indexed directly by the
// low bits of the ALU result.

// 32x32 register file: two asynchronous read ports, one synchronous write port.
module regfile (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  // Zero at power-up so the program runs without needing a reset pulse
  logic [31:0] GPR [0:31] = '{default: '0};

  // Register 0 is hard-wired to zero on the read side
  always_comb begin
    rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : GPR[raddr_a_i];
    rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : GPR[raddr_b_i];
  end

  // Reset clears every register and overrides any pending write
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) begin
        GPR[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      GPR[waddr_i] <= wdata_i;
    end
  end

endmodule

// Data RAM: asynchronous read, synchronous write, cleared by reset.
module dmem #(
  parameter int unsigned DMEM_DEPTH = 256,
  parameter int unsigned AddrW      = $clog2(DMEM_DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [AddrW-1:0] addr_i,
  output logic [31:0]      rdata_o,
  input  logic             we_i,
  input  logic [31:0]      wdata_i
);

  logic [31:0] RAM [0:DMEM_DEPTH-1] = '{default: '0};

  // Asynchronous read
  always_comb begin
    rdata_o = RAM[addr_i];
  end

  // Reset clears the whole array and has priority over a store
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
        RAM[i] <= '0;
      end
    end else if (we_i) begin
      RAM[addr_i] <= wdata_i;
    end
  end

endmodule

module datapath #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ALUout
);

  localparam int unsigned PcW   = $clog2(IMEM_DEPTH);
  localparam int unsigned DAddrW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  typedef enum logic [2:0] {AluZero, AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  logic [PcW-1:0] PCout = '0;
  logic [PcW-1:0] pc_d;
  logic [PcW-1:0] pc_plus1;
  logic [31:0]    Instr;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;

  logic    reg_write, mem_write, alu_src_imm, mem_to_reg, reg_dst_rd;
  logic    branch_eq, branch_ne, jump;
  alu_op_e alu_op;

  logic [31:0] rs_data, rt_data, alu_b, alu_result, ram_rdata, wb_data;
  logic [4:0]  wb_addr;
  logic        alu_zero;

  // Fixed compare-and-swap program; everything else decodes as a NOP
  always_comb begin
    Instr = 32'h0000_0000;
    case (PCout)
      PcW'(0):  Instr = 32'h2001_000A; // addi r1,r0,10
      PcW'(1):  Instr = 32'h2002_0005; // addi r2,r0,5
      PcW'(2):  Instr = 32'hAC01_0000; // sw   r1,0(r0)
      PcW'(3):  Instr = 32'hAC02_0004; // sw   r2,4(r0)
      PcW'(4):  Instr = 32'h8C03_0000; // lw   r3,0(r0)
      PcW'(5):  Instr = 32'h8C04_0004; // lw   r4,4(r0)
      PcW'(6):  Instr = 32'h0064_102A; // slt  r2,r3,r4
      PcW'(7):  Instr = 32'h1440_0002; // bne  r2,r0,+2
      PcW'(8):  Instr = 32'hAC04_0000; // sw   r4,0(r0)
      PcW'(9):  Instr = 32'hAC03_0004; // sw   r3,4(r0)
      PcW'(10): Instr = 32'h8C06_0000; // lw   r6,0(r0)
      PcW'(11): Instr = 32'h8C07_0004; // lw   r7,4(r0)
      PcW'(12): Instr = 32'h0800_000C; // j    12
      default:  Instr = 32'h0000_0000;
    endcase
  end

  assign opcode   = Instr[31:26];
  assign rs       = Instr[25:21];
  assign rt       = Instr[20:16];
  assign rd       = Instr[15:11];
  assign funct    = Instr[5:0];
  assign imm_sext = {{16{Instr[15]}}, Instr[15:0]};

  // Shift amount and high jump-target bits have no role in this subset
  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr[10:6], Instr[25:PcW]};

  // Main decoder: unknown opcodes and unknown R-type functs leave everything idle
  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    alu_src_imm = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst_rd  = 1'b0;
    branch_eq   = 1'b0;
    branch_ne   = 1'b0;
    jump        = 1'b0;
    alu_op      = AluZero;
    case (opcode)
      OpRtype: begin
        reg_dst_rd = 1'b1;
        reg_write  = 1'b1;
        case (funct)
          6'h20:   alu_op = AluAdd;
          6'h22:   alu_op = AluSub;
          6'h24:   alu_op = AluAnd;
          6'h25:   alu_op = AluOr;
          6'h2A:   alu_op = AluSlt;
          default: reg_write = 1'b0;
        endcase
      end
      OpAddi: begin
        alu_src_imm = 1'b1;
        reg_write   = 1'b1;
        alu_op      = AluAdd;
      end
      OpLw: begin
        alu_src_imm = 1'b1;
        mem_to_reg  = 1'b1;
        reg_write   = 1'b1;
        alu_op      = AluAdd;
      end
      OpSw: begin
        alu_src_imm = 1'b1;
        mem_write   = 1'b1;
        alu_op      = AluAdd;
      end
      OpBeq: begin
        branch_eq = 1'b1;
        alu_op    = AluSub;
      end
      OpBne: begin
        branch_ne = 1'b1;
        alu_op    = AluSub;
      end
      OpJ:     jump = 1'b1;
      default: ;
    endcase
  end

  regfile g1 (
    .clk_i     (clk),
    .reset_i   (reset),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data),
    .we_i      (reg_write),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data)
  );

  // ALU with 32-bit wraparound; slt compares as signed
  always_comb begin
    alu_b = alu_src_imm ? imm_sext : rt_data;
    alu_result = 32'd0;
    case (alu_op)
      AluAdd:  alu_result = rs_data + alu_b;
      AluSub:  alu_result = rs_data - alu_b;
      AluAnd:  alu_result = rs_data & alu_b;
      AluOr:   alu_result = rs_data | alu_b;
      AluSlt:  alu_result = ($signed(rs_data) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
    ALUout   = alu_result;
  end

  dmem #(
    .DMEM_DEPTH (DMEM_DEPTH)
  ) d1 (
    .clk_i   (clk),
    .reset_i (reset),
    .addr_i  (alu_result[DAddrW-1:0]),
    .rdata_o (ram_rdata),
    .we_i    (mem_write),
    .wdata_i (rt_data)
  );

  // Write-back selection
  always_comb begin
    wb_addr = reg_dst_rd ? rd : rt;
    wb_data = mem_to_reg ? ram_rdata : alu_result;
  end

  // Next PC: jump, taken branch (relative to PC+1) or sequential
  always_comb begin
    pc_plus1 = PCout + PcW'(1);
    pc_d     = pc_plus1;
    if (jump) begin
      pc_d = Instr[PcW-1:0];
    end else if ((branch_eq && alu_zero) || (branch_ne && !alu_zero)) begin
      pc_d = pc_plus1 + imm_sext[PcW-1:0];
    end
  end

  // PC register; reset wins over any redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      PCout <= '0;
    end else begin
      PCout <= pc_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: an architectural model of the ROM program,
// stepped once per clock, is compared against PC, ALUout, GPR and RAM.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ALUout;

  int n_asserts = 0;
  int n_fail    = 0;

  // Architectural model state
  int          m_pc;
  logic [31:0] m_r   [0:31];
  logic [31:0] m_mem [0:255];

  datapath dut (
    .clk    (clk),
    .reset  (reset),
    .ALUout (ALUout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_r[i] = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
  endtask

  // Expected ALU value for the instruction the model is sitting on
  function automatic logic [31:0] model_alu();
    case (m_pc)
      0:       return 32'd10;
      1:       return 32'd5;
      3, 5:    return 32'd4;
      9, 11:   return 32'd4;
      6:       return ($signed(m_r[3]) < $signed(m_r[4])) ? 32'd1 : 32'd0;
      7:       return m_r[2] - m_r[0];
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the program, written straight from the assembly listing
  task automatic model_edge(input bit rst);
    if (rst) begin
      model_clear();
    end else begin
      case (m_pc)
        0:  m_r[1] = 32'd10;
        1:  m_r[2] = 32'd5;
        2:  m_mem[0] = m_r[1];
        3:  m_mem[4] = m_r[2];
        4:  m_r[3] = m_mem[0];
        5:  m_r[4] = m_mem[4];
        6:  m_r[2] = ($signed(m_r[3]) < $signed(m_r[4])) ? 32'd1 : 32'd0;
        8:  m_mem[0] = m_r[4];
        9:  m_mem[4] = m_r[3];
        10: m_r[6] = m_mem[0];
        11: m_r[7] = m_mem[4];
        default: ;
      endcase
      if (m_pc == 12) m_pc = 12;
      else if (m_pc == 7 && m_r[2] != 0) m_pc = 10;
      else m_pc = m_pc + 1;
    end
  endtask

  task automatic check_state(input string where);
    check({where, " pc"}, 32'(dut.PCout), 32'(m_pc));
    check({where, " aluout"}, ALUout, model_alu());
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("%s gpr%0d", where, i), dut.g1.GPR[i], m_r[i]);
    end
    check({where, " ram0"}, dut.d1.RAM[0], m_mem[0]);
    check({where, " ram4"}, dut.d1.RAM[4], m_mem[4]);
  endtask

  task automatic check_cleared(input string where);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s gpr%0d zero", where, i), dut.g1.GPR[i], 32'd0);
    end
    for (int i = 0; i < 256; i++) begin
      check($sformatf("%s ram%0d zero", where, i), dut.d1.RAM[i], 32'd0);
    end
    check({where, " pc zero"}, 32'(dut.PCout), 32'd0);
    check({where, " aluout after reset"}, ALUout, 32'd10);
  endtask

  // Drive reset for this edge, advance model alongside DUT, then compare
  task automatic tick(input bit rst, input string where);
    reset = rst;
    @(posedge clk);
    model_edge(rst);
    #1;
    reset = 1'b0;
    check_state(where);
  endtask

  task automatic check_final(input string where);
    check({where, " final ram0"}, dut.d1.RAM[0], 32'd5);
    check({where, " final ram4"}, dut.d1.RAM[4], 32'd10);
    check({where, " final gpr6"}, dut.g1.GPR[6], 32'd5);
    check({where, " final gpr7"}, dut.g1.GPR[7], 32'd10);
    check({where, " final pc"}, 32'(dut.PCout), 32'd12);
    check({where, " sorted"},
          32'($signed(dut.d1.RAM[0]) <= $signed(dut.d1.RAM[4])), 32'd1);
  endtask

  initial begin
    model_clear();
    #1;
    // Power-up state without any reset
    check_cleared("powerup");
    check_state("powerup");

    // First run from power-up with directed test-plan checkpoints
    for (int e = 1; e <= 16; e++) begin
      tick(1'b0, $sformatf("run1 e%0d", e));
      if (e == 2) begin
        check("e2 pc", 32'(dut.PCout), 32'd2);
        check("e2 gpr1", dut.g1.GPR[1], 32'd10);
        check("e2 gpr2", dut.g1.GPR[2], 32'd5);
      end
      if (e == 4) begin
        check("e4 ram0", dut.d1.RAM[0], 32'd10);
        check("e4 ram4", dut.d1.RAM[4], 32'd5);
      end
      if (e == 6) begin
        check("e6 gpr3", dut.g1.GPR[3], 32'd10);
        check("e6 gpr4", dut.g1.GPR[4], 32'd5);
      end
      if (e == 7) begin
        check("e7 gpr2", dut.g1.GPR[2], 32'd0);
        check("e7 pc", 32'(dut.PCout), 32'd7);
      end
    end
    check_final("run1");

    // Restart, run to PC=9, then reset for one edge mid-program
    tick(1'b1, "restart");
    for (int e = 1; e <= 9; e++) tick(1'b0, $sformatf("run2 e%0d", e));
    check("run2 pc before reset", 32'(dut.PCout), 32'd9);
    tick(1'b1, "midreset");
    check_cleared("midreset");
    tick(1'b0, "after midreset");
    check("pc1 after midreset", 32'(dut.PCout), 32'd1);
    for (int e = 2; e <= 16; e++) tick(1'b0, $sformatf("run3 e%0d", e));
    check_final("run3");

    // Randomly timed resets of random length
    for (int k = 0; k < 6; k++) begin
      int run_len, rst_len;
      run_len = $urandom_range(0, 15);
      rst_len = $urandom_range(1, 2);
      for (int e = 0; e < run_len; e++) tick(1'b0, $sformatf("rnd%0d run", k));
      for (int e = 0; e < rst_len; e++) tick(1'b1, $sformatf("rnd%0d rst", k));
      check_cleared($sformatf("rnd%0d", k));
    end
    for (int e = 1; e <= 16; e++) tick(1'b0, $sformatf("run4 e%0d", e));
    check_final("run4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Single-cycle MIPS32 subset datapath: PC, built-in instruction ROM, 32x32 register file, ALU, data RAM, branch/jump logic. Top-level core of the processor.
- Executes one instruction per clk rising edge.
- ROM holds a fixed compare-and-swap program that leaves RAM[0] <= RAM[4].

Parameters:
- IMEM_DEPTH, 64, instruction ROM words (word-indexed by PC).
- DMEM_DEPTH, 256, data RAM entries, 32 bits each.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ALUout  output  32  combinational ALU result of the instruction at the current PC.

Behaviour:
- Visible internals: PC register PCout; current instruction Instr; register-file instance g1 with array GPR[0:31]; data-memory instance d1 with array RAM[0:DMEM_DEPTH-1].
- PC counts instructions, not bytes. Default next PC = PC+1.
- beq/bne taken: next PC = PC+1+sign-extended imm16.
- j: next PC = instr[25:0] (truncated to PC width).
- Power-up: PC, all GPR and all RAM initialise to 0 without reset.
- reset high at a clk edge: PC<=0, all GPR<=0, all RAM<=0. No register or memory write from the current instruction. reset has priority over every other update.
- Register file: two asynchronous read ports, one write on clk. GPR[0] always reads 0; writes to it are ignored.
- RAM: asynchronous read; write on clk. Addressed directly by ALU result[7:0] as a byte address, no shift, so RAM[4] is address 4.
- Supported instructions (standard MIPS encodings):
  - R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), rd written.
  - addi 0x08, sign-extended imm.
  - lw 0x23.
  - sw 0x2B.
  - beq 0x04, bne 0x05, compare via subtraction.
  - j 0x02.
- Any other opcode acts as a NOP.
- Arithmetic: 32-bit wraparound, no overflow trap.
- ALUout:
  - equals the ALU result (address for lw/sw, rs-rt for branches).
  - equals 0 for j/NOP.
  - after reset, PC=0 so ALUout=10.
- ROM program (index: instruction):
  - 0: addi r1,r0,10
  - 1: addi r2,r0,5
  - 2: sw r1,0(r0)
  - 3: sw r2,4(r0)
  - 4: lw r3,0(r0)
  - 5: lw r4,4(r0)
  - 6: slt r2,r3,r4
  - 7: bne r2,r0,+2
  - 8: sw r4,0(r0)
  - 9: sw r3,4(r0)
  - 10: lw r6,0(r0)
  - 11: lw r7,4(r0)
  - 12: j 12 (halt loop)
  - remaining ROM words are 0 (NOP).
- Timing: clk period 10 with first edge at t=5. After N edges, PC=N until the halt. PC holds at 12 from the 13th edge onward.
- Reset mid-program restarts the program from PC 0 with cleared state.

Test Plan:
- After 2 edges -> PC=2, GPR[1]=10, GPR[2]=5.
- After 4 edges -> RAM[0]=10, RAM[4]=5.
- After 6 edges -> GPR[3]=10, GPR[4]=5.
- After 7 edges -> GPR[2]=0 (10<5 false), PC=7.
- After 16 edges:
  - RAM[0]=5, RAM[4]=10, GPR[6]=5, GPR[7]=10, PC=12.
  - Ascending-sort check passes.
- Assert reset for one edge at PC=9:
  - PC=0 and all GPR/RAM=0.
  - ALUout=10 the following cycle.
  - Program re-runs to the same final values.
